// File: rtl/vending_machine_n.sv
// Parametrised vending controller: serial price/stock load phase, then a sell phase with
// registered dispense/change/credit responses, overflow coin rejection and in-field restock.
module vending_machine_n #(
    parameter int unsigned N_ITEMS = 4,
    parameter int unsigned PW      = 8,
    parameter int unsigned CW      = 4,
    parameter int unsigned SW      = $clog2(N_ITEMS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    input  logic [PW-1:0]      load_data,
    input  logic [PW-1:0]      coin_in,
    input  logic [SW-1:0]      sel,
    input  logic               refund,
    input  logic               restock,
    output logic               ready,
    output logic               dispense_valid,
    output logic [SW-1:0]      dispense_id,
    output logic [PW:0]        change_out,
    output logic [PW-1:0]      credit,
    output logic [N_ITEMS-1:0] sold_out,
    output logic               empty,
    output logic               sel_err
);

    localparam int unsigned KW = $clog2(2 * N_ITEMS);

    typedef enum logic [0:0] {StLoad, StSell} state_e;

    state_e              state_q, state_d;
    logic [KW-1:0]       load_idx_q, load_idx_d;
    logic [PW-1:0]       price_q [N_ITEMS];
    logic [PW-1:0]       price_d [N_ITEMS];
    logic [CW-1:0]       stock_q [N_ITEMS];
    logic [CW-1:0]       stock_d [N_ITEMS];
    logic [PW-1:0]       credit_q, credit_d;
    logic                dispense_valid_q, dispense_valid_d;
    logic [SW-1:0]       dispense_id_q, dispense_id_d;
    logic [PW:0]         change_q, change_d;
    logic                sel_err_q, sel_err_d;

    logic [PW:0]         eff;
    logic                sel_hit;
    logic [PW-1:0]       sel_price;
    logic [CW-1:0]       sel_stock;

    always_comb begin
        for (int i = 0; i < N_ITEMS; i++) begin
            sold_out[i] = (stock_q[i] == '0);
        end
    end

    assign empty          = (state_q == StSell) && (&sold_out);
    assign ready          = (state_q == StSell);
    assign credit         = credit_q;
    assign dispense_valid = dispense_valid_q;
    assign dispense_id    = dispense_id_q;
    assign change_out     = change_q;
    assign sel_err        = sel_err_q;

    // One extra bit so credit overflow shows up as eff[PW].
    assign eff = {1'b0, credit_q} + {1'b0, coin_in};

    always_comb begin
        sel_hit   = 1'b0;
        sel_price = '0;
        sel_stock = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel == SW'(i + 1)) begin
                sel_hit   = 1'b1;
                sel_price = price_q[i];
                sel_stock = stock_q[i];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        load_idx_d       = load_idx_q;
        price_d          = price_q;
        stock_d          = stock_q;
        credit_d         = credit_q;
        dispense_valid_d = 1'b0;
        dispense_id_d    = '0;
        change_d         = '0;
        sel_err_d        = 1'b0;

        unique case (state_q)
            StLoad: begin
                if (load_valid) begin
                    for (int i = 0; i < N_ITEMS; i++) begin
                        if (load_idx_q == KW'(2 * i)) price_d[i] = load_data;
                        if (load_idx_q == KW'(2 * i + 1)) stock_d[i] = load_data[CW-1:0];
                    end
                    if (load_idx_q == KW'(2 * N_ITEMS - 1)) begin
                        state_d    = StSell;
                        load_idx_d = '0;
                    end else begin
                        load_idx_d = load_idx_q + 1'b1;
                    end
                end
            end
            StSell: begin
                if (refund || empty) begin
                    change_d = eff;
                    credit_d = '0;
                end else if (sel_hit && (sel_stock != '0) && (eff >= {1'b0, sel_price})) begin
                    dispense_valid_d = 1'b1;
                    dispense_id_d    = sel;
                    change_d         = eff - {1'b0, sel_price};
                    credit_d         = '0;
                    for (int i = 0; i < N_ITEMS; i++) begin
                        if (sel == SW'(i + 1)) stock_d[i] = stock_q[i] - 1'b1;
                    end
                end else begin
                    sel_err_d = (sel > SW'(N_ITEMS));
                    if (!eff[PW]) begin
                        credit_d = eff[PW-1:0];
                    end else begin
                        change_d = {1'b0, coin_in};
                    end
                end
                // Restock only from a fully idle machine, so no money is in flight.
                if (restock && (credit_q == '0) && (coin_in == '0) && (sel == '0) && !refund) begin
                    state_d    = StLoad;
                    load_idx_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= StLoad;
            load_idx_q       <= '0;
            price_q          <= '{default: '0};
            stock_q          <= '{default: '0};
            credit_q         <= '0;
            dispense_valid_q <= 1'b0;
            dispense_id_q    <= '0;
            change_q         <= '0;
            sel_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            load_idx_q       <= load_idx_d;
            price_q          <= price_d;
            stock_q          <= stock_d;
            credit_q         <= credit_d;
            dispense_valid_q <= dispense_valid_d;
            dispense_id_q    <= dispense_id_d;
            change_q         <= change_d;
            sel_err_q        <= sel_err_d;
        end
    end

endmodule

// File: tb/tb_vending_machine_n.sv
// Table-driven bench for vending_machine_n (N_ITEMS=4, PW=8, CW=4): each vector's expected
// post-edge outputs go into a scoreboard queue and are popped after the clock edge.
module tb_vending_machine_n;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic [7:0] coin_in = '0;
    logic [2:0] sel = '0;
    logic       refund = 1'b0;
    logic       restock = 1'b0;
    logic       ready;
    logic       dispense_valid;
    logic [2:0] dispense_id;
    logic [8:0] change_out;
    logic [7:0] credit;
    logic [3:0] sold_out;
    logic       empty;
    logic       sel_err;

    vending_machine_n #(
        .N_ITEMS(4),
        .PW     (8),
        .CW     (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .coin_in       (coin_in),
        .sel           (sel),
        .refund        (refund),
        .restock       (restock),
        .ready         (ready),
        .dispense_valid(dispense_valid),
        .dispense_id   (dispense_id),
        .change_out    (change_out),
        .credit        (credit),
        .sold_out      (sold_out),
        .empty         (empty),
        .sel_err       (sel_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lv;
        logic [7:0] ld;
        logic [7:0] coin;
        logic [2:0] sel;
        logic       rf;
        logic       rs;
        logic       rdy;
        logic       dv;
        logic [2:0] id;
        logic [8:0] chg;
        logic [7:0] cr;
        logic [3:0] so;
        logic       emp;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input logic lv, input logic [7:0] ld, input logic [7:0] coin,
                                input logic [2:0] s, input logic rf, input logic rs,
                                input logic rdy, input logic dv, input logic [2:0] id,
                                input logic [8:0] chg, input logic [7:0] cr,
                                input logic [3:0] so, input logic emp, input logic err);
        vec_t v;
        v.lv = lv; v.ld = ld; v.coin = coin; v.sel = s; v.rf = rf; v.rs = rs;
        v.rdy = rdy; v.dv = dv; v.id = id; v.chg = chg; v.cr = cr; v.so = so;
        v.emp = emp; v.err = err;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", nm, idx, act, expv);
        end
    endtask

    task automatic check_outputs(input int idx, input vec_t e);
        check("ready", idx, 32'(ready), 32'(e.rdy));
        check("dispense_valid", idx, 32'(dispense_valid), 32'(e.dv));
        check("dispense_id", idx, 32'(dispense_id), 32'(e.id));
        check("change_out", idx, 32'(change_out), 32'(e.chg));
        check("credit", idx, 32'(credit), 32'(e.cr));
        check("sold_out", idx, 32'(sold_out), 32'(e.so));
        check("empty", idx, 32'(empty), 32'(e.emp));
        check("sel_err", idx, 32'(sel_err), 32'(e.err));
    endtask

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        @(negedge clk);
        load_valid = v.lv;
        load_data  = v.ld;
        coin_in    = v.coin;
        sel        = v.sel;
        refund     = v.rf;
        restock    = v.rs;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_outputs(idx, e);
    endtask

    initial begin
        //         lv ld     coin sel rf rs  rdy dv id chg  cr   so       emp err
        // Initial load: 10/2, 20/1, 30/0, 5/3 (stock upper bits ignored); sell inputs ignored.
        vecs.push_back(mk(1, 10,   0,  0, 0, 0,  0, 0, 0, 0,   0,   4'b1111, 0, 0));
        vecs.push_back(mk(1, 2,    0,  0, 0, 0,  0, 0, 0, 0,   0,   4'b1110, 0, 0));
        vecs.push_back(mk(1, 20,   9,  1, 0, 0,  0, 0, 0, 0,   0,   4'b1110, 0, 0));
        vecs.push_back(mk(1, 1,    0,  0, 0, 0,  0, 0, 0, 0,   0,   4'b1100, 0, 0));
        vecs.push_back(mk(0, 77,  50,  7, 1, 1,  0, 0, 0, 0,   0,   4'b1100, 0, 0));
        vecs.push_back(mk(1, 30,   0,  0, 0, 0,  0, 0, 0, 0,   0,   4'b1100, 0, 0));
        vecs.push_back(mk(1, 0,    0,  0, 0, 0,  0, 0, 0, 0,   0,   4'b1100, 0, 0));
        vecs.push_back(mk(1, 5,    0,  0, 0, 0,  0, 0, 0, 0,   0,   4'b1100, 0, 0));
        vecs.push_back(mk(1, 8'hF3, 0, 0, 0, 0,  1, 0, 0, 0,   0,   4'b0100, 0, 0));
        // Selling.
        vecs.push_back(mk(0, 0,    7,  0, 0, 0,  1, 0, 0, 0,   7,   4'b0100, 0, 0));
        vecs.push_back(mk(0, 0,    5,  0, 0, 0,  1, 0, 0, 0,   12,  4'b0100, 0, 0));
        vecs.push_back(mk(0, 0,    0,  1, 0, 0,  1, 1, 1, 2,   0,   4'b0100, 0, 0));
        vecs.push_back(mk(0, 0,   15,  0, 0, 0,  1, 0, 0, 0,   15,  4'b0100, 0, 0));
        vecs.push_back(mk(0, 0,   10,  2, 0, 0,  1, 1, 2, 5,   0,   4'b0110, 0, 0));
        vecs.push_back(mk(0, 0,   25,  0, 0, 0,  1, 0, 0, 0,   25,  4'b0110, 0, 0));
        vecs.push_back(mk(0, 0,    0,  3, 0, 0,  1, 0, 0, 0,   25,  4'b0110, 0, 0));
        vecs.push_back(mk(0, 0,    0,  0, 1, 0,  1, 0, 0, 25,  0,   4'b0110, 0, 0));
        vecs.push_back(mk(0, 0,  200,  0, 0, 0,  1, 0, 0, 0,   200, 4'b0110, 0, 0));
        vecs.push_back(mk(0, 0,   50,  0, 0, 0,  1, 0, 0, 0,   250, 4'b0110, 0, 0));
        vecs.push_back(mk(0, 0,   10,  0, 0, 0,  1, 0, 0, 10,  250, 4'b0110, 0, 0));
        vecs.push_back(mk(0, 0,    0,  7, 0, 0,  1, 0, 0, 0,   250, 4'b0110, 0, 1));
        vecs.push_back(mk(0, 0,    5,  0, 0, 0,  1, 0, 0, 0,   255, 4'b0110, 0, 0));
        vecs.push_back(mk(0, 0,    1,  5, 0, 0,  1, 0, 0, 1,   255, 4'b0110, 0, 1));
        vecs.push_back(mk(0, 0,    0,  0, 0, 1,  1, 0, 0, 0,   255, 4'b0110, 0, 0));
        vecs.push_back(mk(0, 0,    3,  0, 1, 0,  1, 0, 0, 258, 0,   4'b0110, 0, 0));
        vecs.push_back(mk(0, 0,    4,  1, 0, 0,  1, 0, 0, 0,   4,   4'b0110, 0, 0));
        vecs.push_back(mk(0, 0,    0,  4, 1, 0,  1, 0, 0, 4,   0,   4'b0110, 0, 0));
        // Drain remaining stock, then empty-machine behaviour.
        vecs.push_back(mk(0, 0,   10,  1, 0, 0,  1, 1, 1, 0,   0,   4'b0111, 0, 0));
        vecs.push_back(mk(0, 0,    5,  4, 0, 0,  1, 1, 4, 0,   0,   4'b0111, 0, 0));
        vecs.push_back(mk(0, 0,    5,  4, 0, 0,  1, 1, 4, 0,   0,   4'b0111, 0, 0));
        vecs.push_back(mk(0, 0,    5,  4, 0, 0,  1, 1, 4, 0,   0,   4'b1111, 1, 0));
        vecs.push_back(mk(0, 0,    4,  0, 0, 0,  1, 0, 0, 4,   0,   4'b1111, 1, 0));
        vecs.push_back(mk(0, 0,    0,  6, 0, 0,  1, 0, 0, 0,   0,   4'b1111, 1, 0));
        vecs.push_back(mk(0, 0,    0,  0, 0, 1,  0, 0, 0, 0,   0,   4'b1111, 0, 0));
        // Reload: slot 1 free with one item, slot 4 two items.
        vecs.push_back(mk(1, 0,    0,  0, 0, 0,  0, 0, 0, 0,   0,   4'b1111, 0, 0));
        vecs.push_back(mk(1, 1,    0,  0, 0, 0,  0, 0, 0, 0,   0,   4'b1110, 0, 0));
        vecs.push_back(mk(1, 20,   0,  0, 0, 0,  0, 0, 0, 0,   0,   4'b1110, 0, 0));
        vecs.push_back(mk(1, 0,    0,  0, 0, 0,  0, 0, 0, 0,   0,   4'b1110, 0, 0));
        vecs.push_back(mk(1, 30,   0,  0, 0, 0,  0, 0, 0, 0,   0,   4'b1110, 0, 0));
        vecs.push_back(mk(1, 0,    0,  0, 0, 0,  0, 0, 0, 0,   0,   4'b1110, 0, 0));
        vecs.push_back(mk(1, 40,   0,  0, 0, 0,  0, 0, 0, 0,   0,   4'b1110, 0, 0));
        vecs.push_back(mk(1, 2,    0,  0, 0, 0,  1, 0, 0, 0,   0,   4'b0110, 0, 0));
        vecs.push_back(mk(0, 0,    0,  1, 0, 0,  1, 1, 1, 0,   0,   4'b0111, 0, 0));
        vecs.push_back(mk(0, 0,   30,  0, 0, 0,  1, 0, 0, 0,   30,  4'b0111, 0, 0));

        // Power-on reset state.
        repeat (2) @(posedge clk);
        #1;
        check_outputs(-1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0));
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // Asynchronous reset with credit held: everything cleared without waiting for an edge.
        @(negedge clk);
        load_valid = 1'b0;
        coin_in    = '0;
        sel        = '0;
        #2;
        rst = 1'b0;
        #1;
        check_outputs(-2, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0));
        @(posedge clk);
        #1;
        check_outputs(-3, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        // Back in the load phase: a coin is ignored and a single word does not reach SELL.
        apply(-4, mk(1, 10, 20, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0));
        apply(-5, mk(1, 3,  0,  0, 0, 0, 0, 0, 0, 0, 0, 4'b1110, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
